// File: rtl/pipe_stage_hs.sv
// Pipeline-boundary register with valid/ready handshake, flush and hold.
// Define PIPE_STAGE_SKID_EN to add a skid entry that registers the upstream ready.
module pipe_stage_hs #(
    parameter int unsigned      WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter int unsigned      CLEAR_ON_FLUSH = 1
) (
    input  logic             clk,
    input  logic             rset,
    input  logic             flush,
    input  logic             hold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam bit CLEAR = (CLEAR_ON_FLUSH != 0);

    logic             r_main_v;
    logic [WIDTH-1:0] r_main;
    logic             w_accept;
    logic             w_issue;

    // Handshake: a transfer happens on an edge where valid && ready are both high;
    // valid never depends on ready, and hold masks out_valid so no issue occurs.
    assign out_valid = r_main_v && !hold;
    assign out_data  = r_main;
    assign w_accept  = in_valid && in_ready;
    assign w_issue   = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             r_skid_v;
    logic [WIDTH-1:0] r_skid;

    assign in_ready  = !flush && !hold && !r_skid_v;
    assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};

    always_ff @(posedge clk) begin
        if (!rset) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main   <= RESET_VALUE;
            r_skid   <= RESET_VALUE;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            if (CLEAR) begin
                r_main <= RESET_VALUE;
                r_skid <= RESET_VALUE;
            end
        end else if (!hold) begin
            if (r_skid_v) begin
                // in_ready is low here, so the only event is the skid moving up
                if (w_issue) begin
                    r_main   <= r_skid;
                    r_skid_v <= 1'b0;
                end
            end else if (w_accept) begin
                if (r_main_v && !w_issue) begin
                    r_skid   <= in_data;
                    r_skid_v <= 1'b1;
                end else begin
                    r_main   <= in_data;
                    r_main_v <= 1'b1;
                end
            end else if (w_issue) begin
                r_main_v <= 1'b0;
            end
        end
    end
`else
    assign in_ready  = !flush && !hold && (!r_main_v || out_ready);
    assign occupancy = {1'b0, r_main_v};

    always_ff @(posedge clk) begin
        if (!rset) begin
            r_main_v <= 1'b0;
            r_main   <= RESET_VALUE;
        end else if (flush) begin
            r_main_v <= 1'b0;
            if (CLEAR) begin
                r_main <= RESET_VALUE;
            end
        end else if (!hold) begin
            if (w_accept) begin
                r_main   <= in_data;
                r_main_v <= 1'b1;
            end else if (w_issue) begin
                r_main_v <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: directed vector table plus randomized run against a queue model,
// driving 32-bit, 200-bit (no clear on flush) and 1-bit instances in lockstep.
module tb_pipe_stage_hs;

    localparam logic [199:0] RV200 = {25{8'h3C}};
    localparam logic         RV1   = 1'b1;

    logic         clk = 1'b0;
    logic         rset, flush, hold, in_valid, out_ready;
    logic [31:0]  din;
    logic [199:0] din200;
    logic         din1;

    logic         ir32, ov32, ir200, ov200, ir1, ov1;
    logic [31:0]  od32;
    logic [199:0] od200;
    logic         od1;
    logic [1:0]   occ32, occ200, occ1;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.WIDTH(32), .RESET_VALUE(32'h0), .CLEAR_ON_FLUSH(1)) u_dut32 (
        .clk(clk), .rset(rset), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(ir32), .in_data(din),
        .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .occupancy(occ32));

    pipe_stage_hs #(.WIDTH(200), .RESET_VALUE(RV200), .CLEAR_ON_FLUSH(0)) u_dut200 (
        .clk(clk), .rset(rset), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(ir200), .in_data(din200),
        .out_valid(ov200), .out_ready(out_ready), .out_data(od200), .occupancy(occ200));

    pipe_stage_hs #(.WIDTH(1), .RESET_VALUE(RV1), .CLEAR_ON_FLUSH(1)) u_dut1 (
        .clk(clk), .rset(rset), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(ir1), .in_data(din1),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1));

    function automatic logic [199:0] widen(input logic [31:0] d);
        return {d, d, d, d, d, d, d[7:0]};
    endfunction

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model: ordered queue of held entries ----------------
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    logic [31:0]  m_q[$];
    logic [31:0]  e_od32;
    logic [199:0] e_od200;
    logic         e_od1;
    bit           m_init = 1'b0;

    function automatic logic model_ready();
        if (flush || hold) return 1'b0;
        if (CAP == 2) return m_q.size() < 2;
        return (m_q.size() == 0) || out_ready;
    endfunction

    task automatic check_model();
        logic       e_ir, e_ov;
        logic [1:0] e_occ;
        if (m_init) begin
            e_ir  = model_ready();
            e_ov  = (m_q.size() > 0) && !hold;
            e_occ = 2'(m_q.size());
            chk("ready32", ir32, e_ir);   chk("valid32", ov32, e_ov);   chk("occ32", occ32, e_occ);
            chk("ready200", ir200, e_ir); chk("valid200", ov200, e_ov); chk("occ200", occ200, e_occ);
            chk("ready1", ir1, e_ir);     chk("valid1", ov1, e_ov);     chk("occ1", occ1, e_occ);
            chk("data32", od32, e_od32);
            chk("data200", od200, e_od200);
            chk("data1", od1, e_od1);
        end
    endtask

    task automatic step_model();
        logic acc, iss;
        if (!rset) begin
            m_q.delete();
            e_od32  = '0;
            e_od200 = RV200;
            e_od1   = RV1;
            m_init  = 1'b1;
        end else if (m_init && flush) begin
            m_q.delete();
            e_od32 = '0;
            e_od1  = RV1;
        end else if (m_init && !hold) begin
            acc = in_valid && model_ready();
            iss = (m_q.size() > 0) && out_ready;
            if (iss) void'(m_q.pop_front());
            if (acc) m_q.push_back(din);
            if (m_q.size() > 0) begin
                e_od32  = m_q[0];
                e_od200 = widen(m_q[0]);
                e_od1   = m_q[0][0];
            end
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic h,
                         input logic iv, input logic ordy, input logic [31:0] d);
        rset = r; flush = f; hold = h; in_valid = iv; out_ready = ordy;
        din = d; din200 = widen(d); din1 = d[0];
    endtask

    task automatic advance();
        check_model();
        step_model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        chk_en;
        logic        r, f, h, iv, ordy;
        logic [31:0] d;
        logic        e_ir, e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic r, input logic f, input logic h,
                       input logic iv, input logic ordy, input logic [31:0] d,
                       input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                       input logic [1:0] e_occ);
        vec_t v;
        v.chk_en = c; v.r = r; v.f = f; v.h = h; v.iv = iv; v.ordy = ordy; v.d = d;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
        vecs.push_back(v);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        //  chk r  f  h  iv or  din     ir ov out     occ   (outputs seen before the edge)
        add(0, 0, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00, 0);
        add(1, 0, 0, 0, 0, 0, 32'h00, 1, 0, 32'h00, 0);
        add(1, 1, 0, 0, 0, 1, 32'h00, 1, 0, 32'h00, 0);
        add(1, 1, 0, 0, 1, 1, 32'h11, 1, 0, 32'h00, 0);
        add(1, 1, 0, 0, 1, 1, 32'h22, 1, 1, 32'h11, 1);
        add(1, 1, 0, 0, 1, 1, 32'h33, 1, 1, 32'h22, 1);
        add(1, 1, 0, 0, 0, 1, 32'h00, 1, 1, 32'h33, 1);
        add(1, 1, 0, 0, 0, 1, 32'h00, 1, 0, 32'h33, 0);
        add(1, 1, 0, 0, 1, 1, 32'hAA, 1, 0, 32'h33, 0);
`ifdef PIPE_STAGE_SKID_EN
        add(1, 1, 0, 0, 1, 0, 32'hBB, 1, 1, 32'hAA, 1);
        add(1, 1, 0, 0, 1, 0, 32'hBB, 0, 1, 32'hAA, 2);
        add(1, 1, 0, 0, 1, 0, 32'hBB, 0, 1, 32'hAA, 2);
        add(1, 1, 0, 0, 1, 1, 32'hBB, 0, 1, 32'hAA, 2);
`else
        add(1, 1, 0, 0, 1, 0, 32'hBB, 0, 1, 32'hAA, 1);
        add(1, 1, 0, 0, 1, 0, 32'hBB, 0, 1, 32'hAA, 1);
        add(1, 1, 0, 0, 1, 0, 32'hBB, 0, 1, 32'hAA, 1);
        add(1, 1, 0, 0, 1, 1, 32'hBB, 1, 1, 32'hAA, 1);
`endif
        add(1, 1, 0, 0, 0, 1, 32'h00, 1, 1, 32'hBB, 1);
        add(1, 1, 0, 0, 0, 1, 32'h00, 1, 0, 32'hBB, 0);
        add(1, 1, 0, 0, 1, 0, 32'h5A, 1, 0, 32'hBB, 0);
`ifdef PIPE_STAGE_SKID_EN
        add(1, 1, 0, 0, 1, 0, 32'h5A, 1, 1, 32'h5A, 1);
        add(1, 1, 1, 0, 1, 0, 32'h77, 0, 1, 32'h5A, 2);
`else
        add(1, 1, 0, 0, 1, 0, 32'h5A, 0, 1, 32'h5A, 1);
        add(1, 1, 1, 0, 1, 0, 32'h77, 0, 1, 32'h5A, 1);
`endif
        add(1, 1, 0, 0, 0, 0, 32'h00, 1, 0, 32'h00, 0);
        add(1, 1, 0, 0, 1, 1, 32'hC3, 1, 0, 32'h00, 0);
        add(1, 1, 0, 1, 1, 1, 32'h99, 0, 0, 32'hC3, 1);
        add(1, 1, 0, 1, 1, 1, 32'h99, 0, 0, 32'hC3, 1);
        add(1, 1, 0, 0, 1, 1, 32'h99, 1, 1, 32'hC3, 1);
        add(1, 1, 0, 0, 0, 1, 32'h00, 1, 1, 32'h99, 1);
        add(1, 1, 0, 0, 0, 1, 32'h00, 1, 0, 32'h99, 0);
        add(1, 1, 0, 0, 1, 0, 32'hD4, 1, 0, 32'h99, 0);
        add(1, 0, 1, 1, 1, 1, 32'hE5, 0, 0, 32'hD4, 1);
        add(1, 1, 0, 0, 0, 0, 32'h00, 1, 0, 32'h00, 0);

        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].f, vecs[i].h, vecs[i].iv, vecs[i].ordy, vecs[i].d);
            #1;
            if (vecs[i].chk_en) begin
                chk($sformatf("vec%0d.in_ready", i), ir32, vecs[i].e_ir);
                chk($sformatf("vec%0d.out_valid", i), ov32, vecs[i].e_ov);
                chk($sformatf("vec%0d.out_data", i), od32, vecs[i].e_od);
                chk($sformatf("vec%0d.occupancy", i), occ32, vecs[i].e_occ);
            end
            advance();
        end

        // Randomized traffic including rare reset, flush and hold.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 63) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom());
            #1;
            advance();
        end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        #1;
        check_model();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Generic, parametrised pipeline-boundary register with a valid/ready handshake, flush and hold. It is the replacement for the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Each stage boundary instantiates one copy and concatenates its fields into in_data.
- Adds per-entry valid tracking, back-pressure, and bubble-free flush.
- An optional skid entry breaks the combinational ready path between stages.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VALUE, 0, value loaded into every payload register on reset (WIDTH bits).
- CLEAR_ON_FLUSH, 1: 1 = payload registers load RESET_VALUE on flush; 0 = payload holds its value and only valid bits clear.

Ports:
- clk  in  1  rising-edge clock
- rset  in  1  synchronous, active-low reset
- flush  in  1  discard every held entry this cycle (exception / branch redirect)
- hold  in  1  freeze the stage: no accept, no issue, state unchanged
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  payload presented downstream
- occupancy  out  2  entries held: 0..1, or 0..2 with the skid entry

Behaviour:
- Priority, evaluated per rising clk edge: rset low > flush > hold > normal operation.
- Reset (rset==0 at the edge):
  - All valid bits are 0, all payload registers are RESET_VALUE, occupancy is 0.
  - Outputs after reset: out_valid=0, out_data=RESET_VALUE.
  - A reset mid-transfer drops all entries; nothing is issued afterwards.
- Definitions:
  - accept = in_valid && in_ready.
  - issue = out_valid && out_ready.
  - Latency is 1 cycle: an entry accepted at edge N is on out_data/out_valid after edge N.
- flush:
  - in_ready=0 combinationally while flush=1.
  - At the edge, all valid bits clear; payload registers follow CLEAR_ON_FLUSH.
  - An issue in the flush cycle still counts as a downstream transfer; the stage is empty afterwards.
- hold:
  - in_ready=0 and out_valid=0 combinationally.
  - No register changes.
  - out_data keeps its value.
- Main entry (no skid):
  - in_ready = !flush && !hold && (!main_v || out_ready). This is combinational from out_ready.
  - accept loads main <= in_data and sets main_v=1.
  - issue without accept clears main_v.
  - issue and accept in the same cycle: main is reloaded and main_v stays 1 (back-to-back streaming at one entry per cycle).
- out_valid = main_v && !hold; out_data = main payload.
- When not valid, out_data holds its last value; downstream must ignore it.
- occupancy = main_v (plus skid_v when the skid entry is present).
- Payload is opaque: no arithmetic and no width conversion. Every bit of in_data maps straight through to out_data.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined: a second, skid, entry is added.
  - in_ready = !flush && !hold && !skid_v. This is a registered term; there is no combinational path from out_ready.
  - accept while main_v && !out_ready loads skid and sets skid_v=1.
  - issue while skid_v moves skid into main (main_v stays 1) and clears skid_v.
  - An accept in the same cycle as that move goes to skid only if skid becomes free; otherwise in_ready was already 0.
  - Ordering is strictly FIFO.
  - flush clears both valid bits; reset clears both.
  - occupancy ranges 0..2.
- Undefined: the single-entry behaviour above applies, and occupancy[1] is tied to 0.

Test Plan:
- Reset and idle: rset=0 for 2 cycles, then 1 → out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Stream: in_valid=1 with in_data 0x11,0x22,0x33 and out_ready=1 → out_data 0x11,0x22,0x33 on consecutive cycles, each one cycle after its accept; occupancy stays 1.
- Back-pressure: accept 0xAA, then out_ready=0 for 3 cycles while in_valid=1 with 0xBB.
  - Without skid: in_ready=0 for those cycles and 0xAA is held.
  - With skid: 0xBB goes to skid, occupancy=2, in_ready=0.
  - Releasing out_ready → 0xAA then 0xBB in order.
- Flush: fill with 0x5A (occupancy 1, or 2 with skid) and pulse flush with in_valid=1 carrying 0x77 → next cycle out_valid=0, occupancy=0, 0x77 not accepted, out_data=RESET_VALUE when CLEAR_ON_FLUSH=1.
- Hold: hold=1 for 2 cycles with out_ready=1 and in_valid=1 carrying 0x99 → in_ready=0, out_valid=0, out_data unchanged. After hold=0 the pending entry issues and 0x99 is then accepted.
- Priority: rset=0, flush=1 and hold=1 asserted together with a valid entry held → reset values, occupancy=0. Also run the build with WIDTH=1 and WIDTH=200 under the stream scenario.
